// File: rtl/fb_frame_ctrl.sv
`timescale 1ns/1ps
// Double-buffered frame-buffer write controller: clears the back buffer and z-buffer,
// accepts the depth-tested pixel stream, drains the z-buffer pipeline and swaps on vsync.
module fb_frame_ctrl #(
    parameter int                 SIZE         = 64,
    parameter int                 COLOR_W      = 10,
    parameter int                 DEPTH_W      = 9,
    parameter int                 DRAIN_CYCLES = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
    localparam int                AW           = $clog2(SIZE*SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [AW-1:0]      addr_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               frame_end,
    input  logic               vsync,
    output logic               ready,
    output logic               fb_we,
    output logic               fb_sel,
    output logic [AW-1:0]      fb_addr,
    output logic [COLOR_W-1:0] fb_din,
    output logic               zb_clr_we,
    output logic [AW-1:0]      zb_clr_addr,
    output logic [DEPTH_W-1:0] zb_clr_din,
    output logic               disp_sel,
    output logic [15:0]        frame_count,
    output logic               drop_err
);

    localparam int            DW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE*SIZE - 1);
    localparam logic [DW-1:0] LAST_DRN  = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_DRAW,
        S_DRAIN,
        S_SWAP_WAIT
    } state_t;

    state_t             state, state_nx;
    logic [AW-1:0]      clr_cnt, clr_cnt_nx;
    logic [DW-1:0]      drn_cnt, drn_cnt_nx;
    logic               back, back_nx;
    logic               disp_nx;
    logic [15:0]        frame_count_nx;
    logic               ready_nx;
    logic               fb_we_nx;
    logic [AW-1:0]      fb_addr_nx;
    logic [COLOR_W-1:0] fb_din_nx;
    logic               zb_we_nx;
    logic [AW-1:0]      zb_addr_nx;
    logic               drop_nx;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx       = state;
        clr_cnt_nx     = clr_cnt;
        drn_cnt_nx     = drn_cnt;
        back_nx        = back;
        disp_nx        = disp_sel;
        frame_count_nx = frame_count;
        ready_nx       = 1'b0;
        fb_we_nx       = 1'b0;
        fb_addr_nx     = fb_addr;
        fb_din_nx      = fb_din;
        zb_we_nx       = 1'b0;
        zb_addr_nx     = zb_clr_addr;
        drop_nx        = drop_err;

        case (state)
            S_CLEAR: begin
                fb_we_nx   = 1'b1;
                fb_addr_nx = clr_cnt;
                fb_din_nx  = BG_COLOR;
                zb_we_nx   = 1'b1;
                zb_addr_nx = clr_cnt;
                if (valid_in) begin
                    drop_nx = 1'b1;
                end
                if (clr_cnt == LAST_ADDR) begin
                    clr_cnt_nx = '0;
                    state_nx   = S_DRAW;
                end else begin
                    clr_cnt_nx = clr_cnt + AW'(1);
                end
            end

            S_DRAW: begin
                if (valid_in) begin
                    fb_we_nx   = 1'b1;
                    fb_addr_nx = addr_in;
                    fb_din_nx  = color_in;
                end
                // The pixel qualified alongside frame_end is still taken above.
                if (frame_end) begin
                    drn_cnt_nx = '0;
                    state_nx   = S_DRAIN;
                end else begin
                    ready_nx = 1'b1;
                end
            end

            S_DRAIN: begin
                if (valid_in) begin
                    fb_we_nx   = 1'b1;
                    fb_addr_nx = addr_in;
                    fb_din_nx  = color_in;
                end
                if (drn_cnt == LAST_DRN) begin
                    state_nx = S_SWAP_WAIT;
                end else begin
                    drn_cnt_nx = drn_cnt + DW'(1);
                end
            end

            S_SWAP_WAIT: begin
                if (valid_in) begin
                    drop_nx = 1'b1;
                end
                if (vsync) begin
                    disp_nx        = back;
                    back_nx        = disp_sel;
                    frame_count_nx = frame_count + 16'd1;
                    clr_cnt_nx     = '0;
                    state_nx       = S_CLEAR;
                end
            end

            default: begin
                state_nx = S_CLEAR;
            end
        endcase
    end

    // Write-port registers; fb_sel tracks the back index so it always names the buffer being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt     <= '0;
            drn_cnt     <= '0;
            back        <= 1'b1;
            disp_sel    <= 1'b0;
            frame_count <= '0;
            ready       <= 1'b0;
            fb_we       <= 1'b0;
            fb_sel      <= 1'b1;
            fb_addr     <= '0;
            fb_din      <= '0;
            zb_clr_we   <= 1'b0;
            zb_clr_addr <= '0;
            zb_clr_din  <= '1;
            drop_err    <= 1'b0;
        end else begin
            clr_cnt     <= clr_cnt_nx;
            drn_cnt     <= drn_cnt_nx;
            back        <= back_nx;
            disp_sel    <= disp_nx;
            frame_count <= frame_count_nx;
            ready       <= ready_nx;
            fb_we       <= fb_we_nx;
            fb_sel      <= back;
            fb_addr     <= fb_addr_nx;
            fb_din      <= fb_din_nx;
            zb_clr_we   <= zb_we_nx;
            zb_clr_addr <= zb_addr_nx;
            zb_clr_din  <= '1;
            drop_err    <= drop_nx;
        end
    end

endmodule

// File: doc/fb_frame_ctrl.md
Name: fb_frame_ctrl

Overview:
- Consumes the depth-tested pixel stream from the z-buffer stage (valid, 12-bit pixel address, 10-bit colour) and writes it into the back half of a double-buffered SIZE x SIZE frame buffer.
- Sequences each frame as: clear back buffer and z-buffer, draw, drain the z-buffer pipeline, wait for vsync, swap.
- Drives `ready` back to the rasterizer and a clear port that is muxed onto the z-buffer write port.

Parameters:
- SIZE, 64: frame edge in pixels; address width AW = $clog2(SIZE*SIZE).
- COLOR_W, 10: pixel colour width.
- DEPTH_W, 9: z-buffer entry width.
- DRAIN_CYCLES, 3: cycles to keep accepting pixels after frame_end; covers the z-buffer pipeline.
- BG_COLOR, 0: colour written during clear.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  pixel valid from z-buffer stage.
- addr_in  in  AW  pixel address, x + y*SIZE.
- color_in  in  COLOR_W  pixel colour.
- frame_end  in  1  one-cycle pulse from rasterizer: last pixel of frame issued.
- vsync  in  1  one-cycle pulse from display timing; swap point.
- ready  out  1  rasterizer may issue pixels.
- fb_we  out  1  frame-buffer write enable.
- fb_sel  out  1  buffer index written (the back buffer).
- fb_addr  out  AW  frame-buffer write address.
- fb_din  out  COLOR_W  frame-buffer write data.
- zb_clr_we  out  1  z-buffer clear write enable.
- zb_clr_addr  out  AW  z-buffer clear address.
- zb_clr_din  out  DEPTH_W  clear value, all ones.
- disp_sel  out  1  buffer index the display reads (front).
- frame_count  out  16  completed swaps, wraps at 16'hFFFF -> 0.
- drop_err  out  1  sticky: a pixel arrived while not accepting.

Behaviour:
- **Clock and reset:** one clock; reset is asynchronous and active-low. All outputs are registered.
- **Reset values:**
  - state = CLEAR, clear counter = 0, disp_sel = 0, back index = 1.
  - ready, fb_we, zb_clr_we, drop_err = 0; frame_count = 0.
  - fb_addr, fb_din, zb_clr_addr = 0; zb_clr_din = all ones.
- **Reset mid-operation:** aborts any clear or draw immediately. Restart is always a full clear.
- **States:** CLEAR -> DRAW -> DRAIN -> SWAP_WAIT -> CLEAR.
- **CLEAR:**
  - Each cycle, the counter value c drives: fb_we = 1, fb_addr = c, fb_din = BG_COLOR, fb_sel = back; zb_clr_we = 1, zb_clr_addr = c.
  - Outputs lag the counter by one register stage.
  - Exactly SIZE*SIZE consecutive write cycles, addresses 0..SIZE*SIZE-1 ascending.
  - After the last address, enter DRAW. ready = 1 starting the cycle after the last clear write.
- **DRAW:**
  - Pixel accepted iff valid_in.
  - One cycle later: fb_we = 1, fb_addr = addr_in, fb_din = color_in, fb_sel = back.
  - Back-to-back pixels are written every cycle, with no stall.
  - frame_end -> DRAIN; ready = 0 from the next cycle.
  - A pixel valid in the same cycle as frame_end is accepted.
- **DRAIN:**
  - Lasts exactly DRAIN_CYCLES cycles; pixels are still accepted and written as in DRAW. Then enter SWAP_WAIT.
  - vsync during DRAIN is ignored; the swap waits for the next vsync.
- **SWAP_WAIT:**
  - No writes.
  - On vsync: disp_sel <= back and back <= old disp_sel (toggle both) on the same edge; frame_count += 1; clear counter = 0; go to CLEAR.
- **Dropped pixels:** valid_in in CLEAR or SWAP_WAIT is dropped and sets drop_err. drop_err clears only on reset.
- **Ignored events:** frame_end outside DRAW; vsync outside SWAP_WAIT.
- **Buffer invariant:** fb_sel never equals disp_sel while fb_we = 1.
- **Z-buffer port:** zb_clr_we is never high outside CLEAR, so the integration mux can select on it.

Test Plan:
- **Reset clear:** release rst_n -> fb_we and zb_clr_we high for 4096 consecutive cycles, fb_addr 0..4095, fb_din = 0, zb_clr_din = 9'h1FF, fb_sel = 1, disp_sel = 0. ready rises the cycle after addr 4095.
- **Draw:** pixels (addr 12'h041, colour 10'h3FF) then (addr 12'hFFF, colour 10'h155) on consecutive cycles -> fb_we on the next two cycles with those exact values and fb_sel = 1.
- **Drain and swap:** frame_end, then valid pixels on drain cycles 1..3 -> all three written, ready = 0. vsync 10 cycles later -> disp_sel = 1, frame_count = 1, new clear with fb_sel = 0.
- **Early vsync:** vsync during DRAIN -> no swap. A later vsync in SWAP_WAIT swaps. Pixel in SWAP_WAIT -> not written, drop_err = 1.
- **Mid-clear reset:** assert rst_n low at clear address 2000 -> outputs return to reset values asynchronously. On release, the clear restarts at address 0.
- **Counter wrap:** 65536 frames -> frame_count wraps to 0; disp_sel alternates every swap.
